// File: rtl/clk_ratio_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// clk_ratio_scheduler_pkg
// Shared definitions for the clock-ratio scheduler.
//   - default parameter values (requester count, ratio width, reset ratio)
//   - FSM state encoding (RUN / PEND / PAUSE), also exported as a debug output
// -----------------------------------------------------------------------------
package clk_ratio_scheduler_pkg;

  localparam int N_REQ_DEF       = 3;  // requesters: turbo, tape loader, debug halt
  localparam int DIV_W_DEF       = 4;  // width of one divide ratio
  localparam int DEFAULT_DIV_DEF = 4;  // 14 MHz -> 3.5 MHz

  // RUN   : ratio stable, counter free-running
  // PEND  : a different (ratio, owner) is wanted; waiting for a period boundary
  // PAUSE : ratio 0 applied, CPU clock halted
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_PAUSE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/clk_ratio_scheduler_if.sv
// -----------------------------------------------------------------------------
// clk_ratio_scheduler_if
// Bundles the request side and the clock-enable side of the scheduler.
//
// Request semantics: i_req[k] is a level request, there is no ready signal.
// A requester owns the clock ratio while its bit is set in o_gnt; ownership
// and ratio change together, only on a divided-period boundary (or at once
// when the clock is paused). o_busy is high while a change is waiting,
// o_sw_done pulses for one cycle when it is applied.
//
//   i_req       N_REQ        level request per requester (0 = highest priority)
//   i_div       N_REQ*DIV_W  requested ratio, requester k at [k*DIV_W +: DIV_W]
//   o_gnt       N_REQ        one-hot current owner, 0 = default ratio
//   o_clk_en    1            one-cycle strobe per divided period
//   o_clk_phase 1            divided square wave
//   o_div_cur   DIV_W        ratio currently applied
//   o_busy      1            ratio change pending
//   o_sw_done   1            pulse when a new ratio is applied
//   o_dbg_state 2            FSM state for observation
// -----------------------------------------------------------------------------
interface clk_ratio_scheduler_if
  import clk_ratio_scheduler_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DIV_W = DIV_W_DEF
);
  logic [N_REQ-1:0]       i_req;
  logic [N_REQ*DIV_W-1:0] i_div;
  logic [N_REQ-1:0]       o_gnt;
  logic                   o_clk_en;
  logic                   o_clk_phase;
  logic [DIV_W-1:0]       o_div_cur;
  logic                   o_busy;
  logic                   o_sw_done;
  sched_state_t           o_dbg_state;

  // Control logic side: drives requests, observes the clock enables.
  modport master (
    output i_req, i_div,
    input  o_gnt, o_clk_en, o_clk_phase, o_div_cur, o_busy, o_sw_done, o_dbg_state
  );

  // Scheduler side.
  modport slave (
    input  i_req, i_div,
    output o_gnt, o_clk_en, o_clk_phase, o_div_cur, o_busy, o_sw_done, o_dbg_state
  );
endinterface

// File: rtl/clk_sched_prio_arb.sv
// -----------------------------------------------------------------------------
// clk_sched_prio_arb
// Combinational fixed-priority picker plus ratio mux.
// The lowest-index active request wins; its ratio becomes the target.
// With no request the target is DEFAULT_DIV and the grant is all zero.
//
//   i_req    N_REQ        level requests
//   i_div    N_REQ*DIV_W  packed requested ratios
//   o_gnt    N_REQ        one-hot winner (0 when idle)
//   o_target DIV_W        ratio of the winner, or DEFAULT_DIV
// -----------------------------------------------------------------------------
module clk_sched_prio_arb
  import clk_ratio_scheduler_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEF,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
  parameter int IDX_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*DIV_W-1:0] i_div,
  output logic [N_REQ-1:0]       o_gnt,
  output logic [DIV_W-1:0]       o_target
);

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

  logic [IDX_W-1:0] w_idx;
  logic             w_hit;
  logic [N_REQ-1:0] w_gnt;
  logic [DIV_W-1:0] w_target;

  always_comb begin
    w_idx = '0;
    w_hit = 1'b0;
    // Scan from the top down so the last assignment is the lowest index.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        w_hit = 1'b1;
        w_idx = IDX_W'(k);
      end
    end
    w_gnt    = w_hit ? (N_REQ'(1) << w_idx) : '0;
    w_target = w_hit ? i_div[w_idx*DIV_W +: DIV_W] : DEF_DIV;
  end

  assign o_gnt    = w_gnt;
  assign o_target = w_target;

endmodule

// File: rtl/clk_ratio_scheduler.sv
// -----------------------------------------------------------------------------
// clk_ratio_scheduler
// Arbitrates the CPU clock-divide ratio between several requesters and
// generates the divided clock enable and phase from i_clk. A ratio change
// is applied only on a period boundary, so the divided clock never sees a
// runt or stretched cycle. Ratio 0 halts the divided clock (PAUSE); leaving
// PAUSE does not wait for a boundary.
//
//   i_clk  system clock
//   i_rst  asynchronous, active-low reset
//   bus    clk_ratio_scheduler_if.slave (requests in, clock enables out)
// -----------------------------------------------------------------------------
module clk_ratio_scheduler
  import clk_ratio_scheduler_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEF,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  clk_ratio_scheduler_if.slave  bus
);

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

  sched_state_t     r_state;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div_cur;
  logic [N_REQ-1:0] r_gnt;
  logic             r_clk_en;
  logic             r_clk_phase;
  logic             r_busy;
  logic             r_sw_done;

  logic [N_REQ-1:0] w_gnt_next;
  logic [DIV_W-1:0] w_target;
  logic             w_change;
  logic             w_boundary;
  logic [DIV_W-1:0] w_cnt_inc;

  clk_sched_prio_arb #(
    .N_REQ       (N_REQ),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_arb (
    .i_req    (bus.i_req),
    .i_div    (bus.i_div),
    .o_gnt    (w_gnt_next),
    .o_target (w_target)
  );

  // Phase for a given counter value: high for the second half of the period.
  // A zero ratio (halted) keeps the phase low.
  function automatic logic f_phase(input logic [DIV_W-1:0] cnt,
                                   input logic [DIV_W-1:0] div);
    return (div != '0) && (cnt >= (div >> 1));
  endfunction

  assign w_change   = (w_target != r_div_cur) || (w_gnt_next != r_gnt);
  // div-1 is only meaningful when div != 0; the guard avoids the wrap.
  assign w_boundary = (r_div_cur != '0) && (r_cnt == (r_div_cur - DIV_W'(1)));
  assign w_cnt_inc  = w_boundary ? '0 : (r_cnt + DIV_W'(1));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= ST_RUN;
      r_cnt       <= '0;
      r_div_cur   <= DEF_DIV;
      r_gnt       <= '0;
      r_clk_en    <= 1'b0;
      r_clk_phase <= 1'b0;
      r_busy      <= 1'b0;
      r_sw_done   <= 1'b0;
    end else begin
      r_sw_done <= 1'b0;
      r_clk_en  <= 1'b0;
      case (r_state)
        ST_RUN: begin
          r_clk_en    <= w_boundary;
          r_cnt       <= w_cnt_inc;
          r_clk_phase <= f_phase(w_cnt_inc, r_div_cur);
          if (w_change) begin
            r_state <= ST_PEND;
            r_busy  <= 1'b1;
          end
        end

        ST_PEND: begin
          // The strobe for the last old period is issued even when switching.
          r_clk_en <= w_boundary;
          if (!w_change) begin
            r_state     <= ST_RUN;
            r_busy      <= 1'b0;
            r_cnt       <= w_cnt_inc;
            r_clk_phase <= f_phase(w_cnt_inc, r_div_cur);
          end else if (w_boundary) begin
            r_div_cur   <= w_target;
            r_gnt       <= w_gnt_next;
            r_cnt       <= '0;
            r_clk_phase <= f_phase('0, w_target);
            r_sw_done   <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= (w_target == '0) ? ST_PAUSE : ST_RUN;
          end else begin
            r_cnt       <= w_cnt_inc;
            r_clk_phase <= f_phase(w_cnt_inc, r_div_cur);
          end
        end

        ST_PAUSE: begin
          // Halted: no period to finish, so a new target applies at once.
          r_cnt       <= '0;
          r_clk_phase <= 1'b0;
          r_busy      <= 1'b0;
          if (w_change) begin
            r_div_cur   <= w_target;
            r_gnt       <= w_gnt_next;
            r_clk_phase <= f_phase('0, w_target);
            r_sw_done   <= 1'b1;
            r_state     <= (w_target == '0) ? ST_PAUSE : ST_RUN;
          end
        end

        default: begin
          r_state <= ST_RUN;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_gnt       = r_gnt;
  assign bus.o_clk_en    = r_clk_en;
  assign bus.o_clk_phase = r_clk_phase;
  assign bus.o_div_cur   = r_div_cur;
  assign bus.o_busy      = r_busy;
  assign bus.o_sw_done   = r_sw_done;
  assign bus.o_dbg_state = r_state;

endmodule

// File: tb/tb_clk_ratio_scheduler.sv
// -----------------------------------------------------------------------------
// tb_clk_ratio_scheduler
// Self-checking bench for clk_ratio_scheduler. A negedge monitor keeps an
// independent model of the divided clock (period start, applied ratio and
// owner) and pops expected switches from exp_q on every o_sw_done.
// -----------------------------------------------------------------------------
module tb_clk_ratio_scheduler;
  import clk_ratio_scheduler_pkg::*;

  localparam int N_REQ = 3;
  localparam int DIV_W = 4;
  localparam int W     = N_REQ + DIV_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  clk_ratio_scheduler_if #(.N_REQ(N_REQ), .DIV_W(DIV_W)) bus ();

  clk_ratio_scheduler #(
    .N_REQ       (N_REQ),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (4)
  ) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  int               cycle       = 0;
  int               start_cycle = 0;
  logic [DIV_W-1:0] model_div   = 4'd4;
  logic [N_REQ-1:0] model_gnt   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      cycle++;
      if (rst_n !== 1'b1) begin
        // The reset cycle counts as cnt=0 of the first default period.
        start_cycle = cycle;
        model_div   = 4'd4;
        model_gnt   = '0;
      end else begin
        int               since;
        logic [DIV_W-1:0] old_div;
        logic [W-1:0]     e;
        logic             exp_phase;
        since   = cycle - start_cycle;
        old_div = model_div;
        if (bus.o_clk_en) begin
          check("clk_en_interval", since, model_div);
          start_cycle = cycle;
        end else if (model_div != 0 && since >= model_div) begin
          check("clk_en_missing", bus.o_clk_en, 1);
          start_cycle = cycle;
        end
        if (bus.o_sw_done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_sw_done", bus.o_sw_done, 0);
          end else begin
            e = exp_q.pop_front();
            check("sw_gnt", bus.o_gnt, e[W-1:DIV_W]);
            check("sw_div", bus.o_div_cur, e[DIV_W-1:0]);
            // A running clock switches on a boundary (with the final strobe);
            // leaving PAUSE switches without one.
            check("sw_clk_en", bus.o_clk_en, (old_div != 0));
            model_gnt = e[W-1:DIV_W];
            model_div = e[DIV_W-1:0];
          end
          start_cycle = cycle;
        end
        since     = cycle - start_cycle;
        exp_phase = (model_div != 0) && (since >= (model_div >> 1));
        check("clk_phase", bus.o_clk_phase, exp_phase);
        check("div_cur", bus.o_div_cur, model_div);
        check("gnt", bus.o_gnt, model_gnt);
        if (model_div == 0) check("pause_busy", bus.o_busy, 0);
      end
    end
  end

  // ---------------- stimulus table ----------------
  typedef struct {
    logic [N_REQ-1:0]       req;
    logic [N_REQ*DIV_W-1:0] div;
    logic [N_REQ-1:0]       exp_gnt;
    logic [DIV_W-1:0]       exp_div;
  } vec_t;

  vec_t vecs[9];

  task automatic wait_clk_en(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_clk_en && n < 40);
    check(name, bus.o_clk_en, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},     bus.o_gnt,       0);
    check({tag, "_div"},     bus.o_div_cur,   4);
    check({tag, "_clk_en"},  bus.o_clk_en,    0);
    check({tag, "_phase"},   bus.o_clk_phase, 0);
    check({tag, "_busy"},    bus.o_busy,      0);
    check({tag, "_sw_done"}, bus.o_sw_done,   0);
    check({tag, "_state"},   bus.o_dbg_state, ST_RUN);
  endtask

  initial begin
    int n;
    int settle;
    logic [DIV_W-1:0] prev_div;

    //            req     div(2,1,0)  exp_gnt exp_div
    vecs[0] = '{3'b100, 12'h200, 3'b100, 4'd2};   // single low-priority request
    vecs[1] = '{3'b101, 12'h801, 3'b001, 4'd1};   // priority, ratio 1
    vecs[2] = '{3'b100, 12'h800, 3'b100, 4'd8};   // drop req 0
    vecs[3] = '{3'b110, 12'h830, 3'b010, 4'd3};   // req 1 takes over
    vecs[4] = '{3'b011, 12'h033, 3'b001, 4'd3};   // owner change, same ratio
    vecs[5] = '{3'b010, 12'h000, 3'b010, 4'd0};   // halt
    vecs[6] = '{3'b000, 12'h000, 3'b000, 4'd4};   // release from halt
    vecs[7] = '{3'b001, 12'h00F, 3'b001, 4'd15};  // maximum ratio
    vecs[8] = '{3'b000, 12'h000, 3'b000, 4'd4};   // back to default

    rst_n     = 1'b0;
    bus.i_req = '0;
    bus.i_div = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("rst");
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Default ratio after release: periods of 4, phase 0,0,1,1
    repeat (13) @(negedge clk);

    // Table-driven ratio changes, applied at a random point in the period
    prev_div = 4'd4;
    for (int i = 0; i < 9; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      #1;
      bus.i_req = vecs[i].req;
      bus.i_div = vecs[i].div;
      exp_q.push_back({vecs[i].exp_gnt, vecs[i].exp_div});
      @(negedge clk);
      #1;
      if (prev_div == 0) check("pause_exit_sw_done", bus.o_sw_done, 1);
      else               check("busy_raised", bus.o_busy, 1);
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
        @(negedge clk);
        #1;
        n++;
      end
      check("switch_applied", exp_q.size(), 0);
      exp_q.delete();
      check("busy_cleared", bus.o_busy, 0);
      settle = (vecs[i].exp_div == 0) ? 8 : 2 * vecs[i].exp_div + 3;
      repeat (settle) @(negedge clk);
      prev_div = vecs[i].exp_div;
    end

    // Request withdrawn before the boundary: busy pulses, no switch
    wait_clk_en("withdraw_sync");
    #1;
    bus.i_req = 3'b001;
    bus.i_div = 12'h002;
    @(negedge clk);
    #1 check("withdraw_busy_hi", bus.o_busy, 1);
    bus.i_req = 3'b000;
    @(negedge clk);
    #1;
    check("withdraw_busy_lo", bus.o_busy, 0);
    check("withdraw_state", bus.o_dbg_state, ST_RUN);
    check("withdraw_no_sw", bus.o_sw_done, 0);
    repeat (10) @(negedge clk);

    // Asynchronous reset in the middle of PEND
    wait_clk_en("rst_pend_sync");
    #1;
    bus.i_req = 3'b100;
    bus.i_div = 12'h800;
    @(negedge clk);
    #1 check("rst_pend_busy", bus.o_busy, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    bus.i_req = '0;
    bus.i_div = '0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (13) @(negedge clk);
    #1;
    check("post_rst_div", bus.o_div_cur, 4);
    check("post_rst_gnt", bus.o_gnt, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Time limit in case the stimulus ever stalls
  initial begin
    #200000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: got timeout, wanted end of test");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
